// File: rtl/ms_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ms_timer_scheduler
// Purpose  : One millisecond timebase shared by four countdown channels. Each
//            channel is one-shot or periodic. Expiries latch into per-channel
//            pending bits and are offered one at a time, round-robin, on a
//            valid/ack interrupt handshake. The free-running ms count and the
//            ms tick pulse are exported.
// Ports    : CLK100MHZ, rst          - clock, synchronous active-high reset
//            wr_en/wr_ch/wr_op/wr_period - channel command strobe
//                                      (op 00 stop, 01 one-shot, 10 periodic,
//                                       11 no-op)
//            irq_valid/irq_ch/irq_ack - expiry presentation handshake
//            ms_tick, mscnt           - 1-cycle ms pulse, 32-bit ms count
//            active/pending/overrun   - per-channel status
// Revision : 1.0 - initial release
// ============================================================================
module ms_timer_scheduler #(
    parameter int TICK_DIV = 100000,
    parameter int PERIOD_W = 16
) (
    input  logic                CLK100MHZ,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [1:0]          wr_ch,
    input  logic [1:0]          wr_op,
    input  logic [PERIOD_W-1:0] wr_period,
    output logic                irq_valid,
    output logic [1:0]          irq_ch,
    input  logic                irq_ack,
    output logic                ms_tick,
    output logic [31:0]         mscnt,
    output logic [3:0]          active,
    output logic [3:0]          pending,
    output logic [3:0]          overrun
);

    localparam int                 c_PRESC_W   = $clog2(TICK_DIV);
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [PERIOD_W-1:0]  c_ONE       = PERIOD_W'(1);

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_PRESENT = 1'b1;

    // ---------------- timebase ----------------
    logic [c_PRESC_W-1:0] r_presc;
    logic                 r_tick;
    logic [31:0]          r_mscnt;
    logic                 w_presc_wrap;

    assign w_presc_wrap = (r_presc == c_PRESC_MAX);

    // r_tick is high in the cycle after the prescaler sat at its last count,
    // together with the incremented mscnt; channels act on r_tick.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_mscnt <= '0;
        end else if (w_presc_wrap) begin
            r_presc <= '0;
            r_tick  <= 1'b1;
            r_mscnt <= r_mscnt + 32'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
            r_tick  <= 1'b0;
        end
    end

    // ---------------- channels ----------------
    logic [PERIOD_W-1:0] r_rem    [4];
    logic [PERIOD_W-1:0] r_period [4];
    logic [3:0]          r_run;
    logic [3:0]          r_mode;   // 1 = periodic
    logic [3:0]          r_pend;
    logic [3:0]          r_ovr;

    logic [3:0]          w_start;
    logic [3:0]          w_stop;
    logic [3:0]          w_expire;
    logic [3:0]          w_clr;
    logic [PERIOD_W-1:0] w_period_eff;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [1:0]          r_irq_ch;
    logic [1:0]          w_irq_ch_nxt;
    logic [1:0]          r_ptr;
    logic [1:0]          w_ptr_nxt;
    logic                w_ack_fire;

    // A zero period behaves like one ms so a start never stalls.
    assign w_period_eff = (wr_period == '0) ? c_ONE : wr_period;
    assign w_ack_fire   = (r_state == c_ST_PRESENT) && irq_ack;

    always_comb begin
        w_start  = '0;
        w_stop   = '0;
        w_expire = '0;
        w_clr    = '0;
        for (int i = 0; i < 4; i++) begin
            w_start[i]  = wr_en && (wr_ch == 2'(i)) &&
                          ((wr_op == 2'b01) || (wr_op == 2'b10));
            w_stop[i]   = wr_en && (wr_ch == 2'(i)) && (wr_op == 2'b00);
            // A command to the channel in the tick cycle pre-empts the tick.
            w_expire[i] = r_tick && r_run[i] && (r_rem[i] <= c_ONE) &&
                          !w_start[i] && !w_stop[i];
            w_clr[i]    = w_ack_fire && (r_irq_ch == 2'(i));
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            r_run  <= '0;
            r_mode <= '0;
            r_pend <= '0;
            r_ovr  <= '0;
            for (int i = 0; i < 4; i++) begin
                r_rem[i]    <= '0;
                r_period[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_start[i]) begin
                    r_period[i] <= w_period_eff;
                    r_rem[i]    <= w_period_eff;
                    r_mode[i]   <= wr_op[1];
                    r_run[i]    <= 1'b1;
                end else if (w_stop[i]) begin
                    r_run[i]    <= 1'b0;
                end else if (r_tick && r_run[i]) begin
                    if (r_rem[i] > c_ONE) begin
                        r_rem[i] <= r_rem[i] - c_ONE;
                    end else if (r_mode[i]) begin
                        r_rem[i] <= r_period[i];
                    end else begin
                        r_run[i] <= 1'b0;
                    end
                end

                // A fresh expiry beats a same-cycle ack of that channel.
                if (w_stop[i]) begin
                    r_pend[i] <= 1'b0;
                    r_ovr[i]  <= 1'b0;
                end else if (w_expire[i]) begin
                    r_pend[i] <= 1'b1;
                    if (r_pend[i]) begin
                        r_ovr[i] <= 1'b1;
                    end
                end else if (w_clr[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- interrupt presentation FSM ----------------
    logic [3:0] w_req;
    logic [1:0] w_pick;
    logic [1:0] w_idx;
    logic       w_found;

    // Channels being stopped this cycle are not eligible for selection.
    assign w_req = r_pend & ~w_stop;

    // Round-robin search: descending k so the nearest channel to r_ptr wins.
    always_comb begin
        w_pick  = r_ptr;
        w_found = 1'b0;
        w_idx   = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (w_req[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_irq_ch <= '0;
            r_ptr    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_irq_ch <= w_irq_ch_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_irq_ch_nxt = r_irq_ch;
        w_ptr_nxt    = r_ptr;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt  = c_ST_PRESENT;
                    w_irq_ch_nxt = w_pick;
                end
            end
            default: begin
                if (irq_ack) begin
                    w_state_nxt = c_ST_IDLE;
                    w_ptr_nxt   = r_irq_ch + 2'd1;
                end else if (w_stop[r_irq_ch]) begin
                    // Presented channel was stopped: withdraw without an ack.
                    w_state_nxt = c_ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        irq_valid = (r_state == c_ST_PRESENT);
        irq_ch    = r_irq_ch;
    end

    assign ms_tick = r_tick;
    assign mscnt   = r_mscnt;
    assign active  = r_run;
    assign pending = r_pend;
    assign overrun = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_ms_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ms_timer_scheduler
// Purpose  : Directed self-checking bench for ms_timer_scheduler with
//            TICK_DIV=4. Expected interrupt channels are queued when the
//            stimulus that causes the expiry is issued and popped when the
//            DUT presents an expiry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ms_timer_scheduler;

    localparam int TICK_DIV = 4;
    localparam int PERIOD_W = 16;

    logic                CLK100MHZ;
    logic                rst;
    logic                wr_en;
    logic [1:0]          wr_ch;
    logic [1:0]          wr_op;
    logic [PERIOD_W-1:0] wr_period;
    logic                irq_valid;
    logic [1:0]          irq_ch;
    logic                irq_ack;
    logic                ms_tick;
    logic [31:0]         mscnt;
    logic [3:0]          active;
    logic [3:0]          pending;
    logic [3:0]          overrun;

    int total = 0;
    int bad   = 0;
    int n;
    int q_exp[$];

    ms_timer_scheduler #(
        .TICK_DIV (TICK_DIV),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_op     (wr_op),
        .wr_period (wr_period),
        .irq_valid (irq_valid),
        .irq_ch    (irq_ch),
        .irq_ack   (irq_ack),
        .ms_tick   (ms_tick),
        .mscnt     (mscnt),
        .active    (active),
        .pending   (pending),
        .overrun   (overrun)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK100MHZ);
    endtask

    // Advance to the next negedge where ms_tick is high; n = cycles taken.
    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK100MHZ);
            cyc++;
        end while (ms_tick !== 1'b1 && cyc < 20);
        if (ms_tick !== 1'b1) chk("tick_timeout", 32'(cyc), 32'(TICK_DIV));
    endtask

    // Land on the first non-tick cycle after a tick.
    task automatic to_phase1();
        int c;
        wait_tick(c);
        step();
    endtask

    task automatic do_write(input logic [1:0] ch, input logic [1:0] op, input logic [PERIOD_W-1:0] per);
        wr_en     = 1'b1;
        wr_ch     = ch;
        wr_op     = op;
        wr_period = per;
        step();
        wr_en     = 1'b0;
    endtask

    // Called in the cycle the presentation is due: checks it against the queue.
    task automatic expect_present(input string tag);
        int e;
        chk({tag, "_valid"}, 32'(irq_valid), 32'd1);
        if (q_exp.size() == 0) begin
            chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = q_exp.pop_front();
            chk({tag, "_ch"}, 32'(irq_ch), 32'(e));
        end
    endtask

    task automatic ack_and_check(input string tag);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk({tag, "_valid_drop"}, 32'(irq_valid), 32'd0);
    endtask

    // ch0, ch2, ch3 expire on the same tick; acked immediately in RR order.
    task automatic rr_round(input string tag);
        int c;
        wait_tick(c);
        step();
        do_write(2'd0, 2'b01, 16'd2);
        do_write(2'd2, 2'b01, 16'd2);
        do_write(2'd3, 2'b01, 16'd2);
        q_exp.push_back(0);
        q_exp.push_back(2);
        q_exp.push_back(3);
        wait_tick(c);
        step();
        chk({tag, "_pending"}, 32'(pending), 32'b1101);
        step();
        for (int i = 0; i < 3; i++) begin
            expect_present(tag);
            ack_and_check(tag);
            if (i < 2) step();
        end
        chk({tag, "_pending_done"}, 32'(pending), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_ch     = '0;
        wr_op     = '0;
        wr_period = '0;
        irq_ack   = 1'b0;

        // ---- reset / timebase ----
        repeat (3) step();
        chk("rst_mscnt",   mscnt, 32'd0);
        chk("rst_tick",    32'(ms_tick), 32'd0);
        chk("rst_active",  32'(active), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_irq",     32'(irq_valid), 32'd0);
        rst = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            wait_tick(n);
            chk("tick_spacing", 32'(n), 32'(TICK_DIV));
            chk("mscnt_count", mscnt, 32'(t));
        end
        force dut.r_mscnt = 32'hFFFF_FFFF;
        step();
        release dut.r_mscnt;
        wait_tick(n);
        chk("mscnt_wrap", mscnt, 32'd0);

        // ---- one-shot ch1, period 3 ----
        step();
        do_write(2'd1, 2'b01, 16'd3);
        q_exp.push_back(1);
        chk("os_active", 32'(active), 32'b0010);
        repeat (3) wait_tick(n);
        chk("os_not_yet", 32'(pending), 32'd0);
        step();
        chk("os_pending", 32'(pending), 32'b0010);
        chk("os_inactive", 32'(active), 32'd0);
        chk("os_irq_latency", 32'(irq_valid), 32'd0);
        step();
        expect_present("os");
        ack_and_check("os");
        chk("os_pending_clr", 32'(pending), 32'd0);

        // ---- periodic ch0, period 2, never acked ----
        to_phase1();
        do_write(2'd0, 2'b10, 16'd2);
        q_exp.push_back(0);
        repeat (2) wait_tick(n);
        step();
        chk("per_pending", 32'(pending), 32'b0001);
        chk("per_no_ovr", 32'(overrun), 32'd0);
        step();
        expect_present("per");
        repeat (2) wait_tick(n);
        step();
        chk("per_overrun", 32'(overrun), 32'b0001);
        chk("per_active", 32'(active), 32'b0001);
        chk("per_still_valid", 32'(irq_valid), 32'd1);
        do_write(2'd0, 2'b00, 16'd0);
        chk("per_stop_pending", 32'(pending), 32'd0);
        chk("per_stop_overrun", 32'(overrun), 32'd0);
        chk("per_stop_active", 32'(active), 32'd0);
        chk("per_stop_withdraw", 32'(irq_valid), 32'd0);

        // ---- ch3 period 1 one-shot, acked: RR pointer back to 0 ----
        to_phase1();
        do_write(2'd3, 2'b01, 16'd1);
        q_exp.push_back(3);
        wait_tick(n);
        step();
        step();
        expect_present("ptr");
        ack_and_check("ptr");

        // ---- round robin, twice ----
        rr_round("rr1");
        rr_round("rr2");

        // ---- restart in the tick cycle: write wins ----
        to_phase1();
        do_write(2'd2, 2'b01, 16'd1);
        wait_tick(n);
        do_write(2'd2, 2'b01, 16'd5);
        chk("coll_wr_no_expire", 32'(pending), 32'd0);
        chk("coll_wr_active", 32'(active), 32'b0100);
        repeat (4) wait_tick(n);
        step();
        chk("coll_wr_rem5_early", 32'(pending), 32'd0);
        wait_tick(n);
        q_exp.push_back(2);
        step();
        chk("coll_wr_rem5_expire", 32'(pending), 32'b0100);
        step();
        expect_present("coll_wr");
        ack_and_check("coll_wr");

        // ---- ack and re-expire of ch0 in the same cycle ----
        to_phase1();
        do_write(2'd0, 2'b10, 16'd1);
        q_exp.push_back(0);
        wait_tick(n);
        step();
        chk("coll_ack_pending0", 32'(pending), 32'b0001);
        step();
        expect_present("coll_ack");
        repeat (2) step();
        chk("coll_ack_in_tick", 32'(ms_tick), 32'd1);
        ack_and_check("coll_ack");
        chk("coll_ack_pending", 32'(pending), 32'b0001);
        chk("coll_ack_overrun", 32'(overrun), 32'b0001);
        do_write(2'd0, 2'b00, 16'd0);
        chk("coll_ack_stop", 32'({active, pending, overrun}), 32'd0);
        chk("coll_ack_no_present", 32'(irq_valid), 32'd0);

        // ---- period 0 behaves as period 1 ----
        to_phase1();
        do_write(2'd1, 2'b01, 16'd0);
        q_exp.push_back(1);
        wait_tick(n);
        step();
        chk("p0_pending", 32'(pending), 32'b0010);
        chk("p0_inactive", 32'(active), 32'd0);
        step();
        expect_present("p0");
        ack_and_check("p0");

        // ---- withdraw presented ch3 by stopping it ----
        to_phase1();
        do_write(2'd3, 2'b01, 16'd1);
        q_exp.push_back(3);
        wait_tick(n);
        step();
        step();
        expect_present("wd");
        do_write(2'd3, 2'b00, 16'd0);
        chk("wd_valid", 32'(irq_valid), 32'd0);
        chk("wd_pending", 32'(pending), 32'd0);
        step();
        chk("wd_stays_idle", 32'(irq_valid), 32'd0);
        chk("sb_empty", 32'(q_exp.size()), 32'd0);

        // ---- reset mid-operation ----
        to_phase1();
        do_write(2'd1, 2'b10, 16'd1);
        do_write(2'd2, 2'b01, 16'd1);
        wait_tick(n);
        step();
        chk("mid_pending", 32'(pending), 32'b0110);
        chk("mid_active", 32'(active), 32'b0010);
        rst = 1'b1;
        step();
        chk("mid_rst_outs",
            {ms_tick, irq_valid, irq_ch, active, pending, overrun, 16'd0}, 32'd0);
        chk("mid_rst_mscnt", mscnt, 32'd0);
        rst = 1'b0;
        wait_tick(n);
        chk("mid_rst_first_tick", 32'(n), 32'(TICK_DIV));
        chk("mid_rst_mscnt1", mscnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ms_timer_scheduler.md
Name: ms_timer_scheduler

Overview:
- Shares one millisecond timebase among 4 independent countdown channels for the system's software/OS layer.
- Each channel is one-shot or periodic.
- Expiries are queued as per-channel pending bits and delivered one at a time on a round-robin interrupt handshake.
- Also exports the free-running ms count and tick used elsewhere in the system.

Parameters:
- TICK_DIV, 100000, CLK100MHZ cycles per ms tick (>=2).
- PERIOD_W, 16, width of channel period/remaining counters.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  one-cycle command strobe.
- wr_ch  in  2  target channel.
- wr_op  in  2  00 stop, 01 start one-shot, 10 start periodic, 11 ignored (no-op).
- wr_period  in  PERIOD_W  period in ms for start ops.
- irq_valid  out  1  an expiry is being presented.
- irq_ch  out  2  channel of presented expiry, stable while irq_valid.
- irq_ack  in  1  consumer accepts presented expiry.
- ms_tick  out  1  one-cycle pulse per ms.
- mscnt  out  32  free-running ms count, wraps 0xFFFFFFFF->0.
- active  out  4  channel running.
- pending  out  4  channel expired, not yet acked.
- overrun  out  4  sticky: expiry while already pending.

Behaviour:
- Reset values: all outputs 0; prescaler 0; all channels IDLE; RR pointer 0; IRQ FSM IDLE.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - In the cycle it equals TICK_DIV-1: returns to 0 and ms_tick=1 (registered, same cycle).
  - mscnt increments in that same cycle.
  - First tick asserts TICK_DIV cycles after rst deasserts.
- Channel state per ch: IDLE / RUN, plus remaining[PERIOD_W], period reg, mode bit.
- Start (op 01/10):
  - period<=wr_period, remaining<=wr_period, mode set, state RUN, active=1.
  - wr_period==0 is treated as 1.
  - Restart while RUN reloads; pending/overrun unchanged.
- Stop (op 00): state IDLE, active=0; clears pending and overrun of that ch.
- Tick on a RUN ch:
  - remaining>1: decrement.
  - remaining==1: expire.
    - If pending already 1: overrun<=1.
    - pending<=1.
    - Periodic: remaining<=period, stays RUN.
    - One-shot: IDLE, active=0.
- Write and tick same cycle, same ch: write wins; tick ignored for that ch only.
- Expiry latency: pending visible the cycle after the tick cycle.
- IRQ FSM:
  - IDLE: if pending!=0, pick first set bit searching from RR pointer upward (mod 4); next cycle PRESENT with irq_valid=1, irq_ch=pick.
  - PRESENT: hold irq_ch.
    - On irq_ack: clear pending[irq_ch], pointer<=irq_ch+1, go IDLE; irq_valid=0 next cycle.
    - Minimum one idle cycle between presentations.
- irq_ack while irq_valid=0: ignored.
- Ack and new expiry of the same ch in the same cycle: set wins; pending stays 1, overrun<=1.
- Stop of the presented ch while PRESENT: pending cleared, FSM returns IDLE, irq_valid=0 next cycle (withdrawn, no ack needed). Stop of other channels does not disturb the presentation.
- Reset mid-operation: everything returns to reset values in the next cycle regardless of tick/handshake state.
- Widths: remaining/period are PERIOD_W unsigned; mscnt 32-bit modular.

Test Plan (TICK_DIV=4 unless stated):
- Reset/timebase: hold rst 3 cycles, release. ms_tick pulses at cycles 4,8,12 after release; mscnt reads 1,2,3 after each. Preset mscnt path to 0xFFFFFFFF: next tick wraps to 0.
- One-shot: start ch1 period 3. After 3rd tick: pending=0010, active[1]=0; irq_valid=1, irq_ch=1 one cycle later. Ack: pending=0000, irq_valid drops next cycle.
- Periodic + overrun: start ch0 periodic period 2, never ack. pending[0] sets after tick 2. overrun[0]=1 after tick 4. active[0] stays 1. Stop ch0 clears pending, overrun and active.
- Round-robin: ch0, ch2, ch3 expire on the same tick, pointer 0. Ack each immediately: irq_ch sequence 0,2,3 with one idle cycle between. Re-expire all three, pointer now 0: order 0,2,3 again.
- Collisions:
  - Start ch2 period 5 in the tick cycle: tick ignored, remaining=5.
  - Ack ch0 in the same cycle as ch0 re-expires: pending[0]=1, overrun[0]=1.
  - Period 0 start: expires on the first tick.
- Withdraw/reset: ch3 presented, stop ch3: irq_valid=0 next cycle, no ack. Assert rst while ch1 RUN with pending=0110: all outputs 0 next cycle.
